// File: rtl/alu_ctrl_pipe.sv
// alu_ctrl_pipe: decode-to-execute ALU control register with an optional
// multiply/divide sequencing FSM.
//
// Decodes RV32 op/funct3/funct7 into an ALU select code and registers it into
// the execute stage, with a latency of one cycle. Unrecognised encodings
// register as add with illegal_e set.
//
// Optional feature: define ALU_CTRL_MEXT_EN to enable M-extension sequencing.
// When the feature is enabled, an R-type instruction with funct7 0x01 is
// accepted into a BUSY state for MD_CYCLES cycles. While BUSY, the decode stage
// is held, and the op completes as ALU code 12. When the feature is disabled,
// funct7 0x01 decodes as illegal and stall_d/md_start/md_op/md_kill are tied to 0.
//
// Parameters:
//   CTRL_W     width of ALUControlE (min 4; code zero-extended)
//   MD_CYCLES  busy cycles per multiply/divide op (min 2)
// Ports:
//   clk, rst               rising-edge clock, async active-high reset
//   valid_d                decode-stage instruction valid
//   op, funct3, funct7     instruction fields
//   stall_in               downstream hold
//   flush                  kill in-flight op, clear execute register
//   ALUControlE            registered ALU select
//   valid_e, illegal_e     execute-stage valid / illegal-encoding flag
//   stall_d                hold decode stage (FSM busy)
//   md_start               one-cycle pulse in first busy cycle
//   md_op                  funct3 of the accepted mul/div op
//   md_kill                one-cycle pulse after a flush aborts a busy op
module alu_ctrl_pipe #(
    parameter int unsigned CTRL_W    = 4,
    parameter int unsigned MD_CYCLES = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              valid_d,
    input  logic [6:0]        op,
    input  logic [2:0]        funct3,
    input  logic [6:0]        funct7,
    input  logic              stall_in,
    input  logic              flush,
    output logic [CTRL_W-1:0] ALUControlE,
    output logic              valid_e,
    output logic              illegal_e,
    output logic              stall_d,
    output logic              md_start,
    output logic [2:0]        md_op,
    output logic              md_kill
);

`ifdef ALU_CTRL_MEXT_EN
    localparam bit MextEn = 1'b1;
`else
    localparam bit MextEn = 1'b0;
`endif

    localparam int unsigned CntW = $clog2(MD_CYCLES);

    localparam logic [3:0] CtrlAdd  = 4'd0;
    localparam logic [3:0] CtrlSub  = 4'd1;
    localparam logic [3:0] CtrlAnd  = 4'd2;
    localparam logic [3:0] CtrlOr   = 4'd3;
    localparam logic [3:0] CtrlXor  = 4'd4;
    localparam logic [3:0] CtrlSlt  = 4'd5;
    localparam logic [3:0] CtrlSltu = 4'd6;
    localparam logic [3:0] CtrlSll  = 4'd7;
    localparam logic [3:0] CtrlSrl  = 4'd8;
    localparam logic [3:0] CtrlSra  = 4'd9;
    localparam logic [3:0] CtrlPassB = 4'd10;
    localparam logic [3:0] CtrlMd   = 4'd12;

    localparam logic [6:0] OpR      = 7'b0110011;
    localparam logic [6:0] OpI      = 7'b0010011;
    localparam logic [6:0] OpLoad   = 7'b0000011;
    localparam logic [6:0] OpStore  = 7'b0100011;
    localparam logic [6:0] OpJalr   = 7'b1100111;
    localparam logic [6:0] OpJal    = 7'b1101111;
    localparam logic [6:0] OpBranch = 7'b1100011;
    localparam logic [6:0] OpLui    = 7'b0110111;

    typedef enum logic [0:0] {StIdle, StBusy} state_e;

    state_e            state_q;
    logic [CntW-1:0]   cnt_q;
    logic [CTRL_W-1:0] ctrl_q;
    logic              valid_q;
    logic              illegal_q;
    logic              md_start_q;
    logic [2:0]        md_op_q;
    logic              md_kill_q;

    logic [3:0] dec_ctrl;
    logic       dec_illegal;
    logic       dec_is_m;

    // Shared funct3 mapping for the non-alternate R-type / I-type ops.
    function automatic logic [3:0] base_op(input logic [2:0] f3);
        logic [3:0] code;
        case (f3)
            3'd0:    code = CtrlAdd;
            3'd1:    code = CtrlSll;
            3'd2:    code = CtrlSlt;
            3'd3:    code = CtrlSltu;
            3'd4:    code = CtrlXor;
            3'd5:    code = CtrlSrl;
            3'd6:    code = CtrlOr;
            default: code = CtrlAnd;
        endcase
        return code;
    endfunction

    always_comb begin
        dec_ctrl    = CtrlAdd;
        dec_illegal = 1'b0;
        dec_is_m    = 1'b0;
        case (op)
            OpR: begin
                if (funct7 == 7'h00) begin
                    dec_ctrl = base_op(funct3);
                end else if (funct7 == 7'h20 && funct3 == 3'd0) begin
                    dec_ctrl = CtrlSub;
                end else if (funct7 == 7'h20 && funct3 == 3'd5) begin
                    dec_ctrl = CtrlSra;
                end else if (funct7 == 7'h01 && MextEn) begin
                    dec_is_m = 1'b1;
                end else begin
                    dec_illegal = 1'b1;
                end
            end
            OpI: begin
                if (funct3 == 3'd1) begin
                    if (funct7 == 7'h00) dec_ctrl = CtrlSll;
                    else dec_illegal = 1'b1;
                end else if (funct3 == 3'd5) begin
                    if (funct7 == 7'h00) dec_ctrl = CtrlSrl;
                    else if (funct7 == 7'h20) dec_ctrl = CtrlSra;
                    else dec_illegal = 1'b1;
                end else begin
                    // funct7 is immediate bits here, so it is ignored.
                    dec_ctrl = base_op(funct3);
                end
            end
            OpLoad, OpStore, OpJalr, OpJal: dec_ctrl = CtrlAdd;
            OpBranch: begin
                if (funct3 == 3'd2 || funct3 == 3'd3) dec_illegal = 1'b1;
                else dec_ctrl = CtrlSub;
            end
            OpLui:   dec_ctrl = CtrlPassB;
            default: dec_illegal = 1'b1;
        endcase
    end

    // Flush outranks everything, then a busy FSM or downstream stall holds the
    // execute register, otherwise decode is captured.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            ctrl_q     <= '0;
            valid_q    <= 1'b0;
            illegal_q  <= 1'b0;
            md_start_q <= 1'b0;
            md_op_q    <= 3'b000;
            md_kill_q  <= 1'b0;
        end else begin
            md_start_q <= 1'b0;
            md_kill_q  <= 1'b0;
            if (flush) begin
                md_kill_q <= (state_q == StBusy);
                state_q   <= StIdle;
                cnt_q     <= '0;
                ctrl_q    <= '0;
                valid_q   <= 1'b0;
                illegal_q <= 1'b0;
            end else if (state_q == StBusy) begin
                if (cnt_q != '0) begin
                    cnt_q <= cnt_q - CntW'(1);
                end else if (!stall_in) begin
                    state_q   <= StIdle;
                    ctrl_q    <= CTRL_W'(CtrlMd);
                    valid_q   <= 1'b1;
                    illegal_q <= 1'b0;
                end
            end else if (!stall_in) begin
                if (valid_d && dec_is_m) begin
                    state_q    <= StBusy;
                    cnt_q      <= CntW'(MD_CYCLES - 1);
                    md_op_q    <= funct3;
                    md_start_q <= 1'b1;
                    ctrl_q     <= '0;
                    valid_q    <= 1'b0;
                    illegal_q  <= 1'b0;
                end else begin
                    ctrl_q    <= CTRL_W'(dec_ctrl);
                    valid_q   <= valid_d;
                    illegal_q <= valid_d & dec_illegal;
                end
            end
        end
    end

    assign ALUControlE = ctrl_q;
    assign valid_e     = valid_q;
    assign illegal_e   = illegal_q;
    assign stall_d     = MextEn && (state_q == StBusy);
    assign md_start    = MextEn && md_start_q;
    assign md_op       = MextEn ? md_op_q : 3'b000;
    assign md_kill     = MextEn && md_kill_q;

endmodule

// File: tb/tb_alu_ctrl_pipe.sv
// Directed self-checking bench for alu_ctrl_pipe (CTRL_W=4, MD_CYCLES=4).
// Multiply/divide scenarios are selected by ALU_CTRL_MEXT_EN, matching the DUT build.
module tb_alu_ctrl_pipe;

    localparam int unsigned MdCycles = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       valid_d;
    logic [6:0] op;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic       stall_in;
    logic       flush;
    logic [3:0] ALUControlE;
    logic       valid_e;
    logic       illegal_e;
    logic       stall_d;
    logic       md_start;
    logic [2:0] md_op;
    logic       md_kill;

    int total = 0;
    int bad   = 0;

    alu_ctrl_pipe #(
        .CTRL_W    (4),
        .MD_CYCLES (MdCycles)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .valid_d     (valid_d),
        .op          (op),
        .funct3      (funct3),
        .funct7      (funct7),
        .stall_in    (stall_in),
        .flush       (flush),
        .ALUControlE (ALUControlE),
        .valid_e     (valid_e),
        .illegal_e   (illegal_e),
        .stall_d     (stall_d),
        .md_start    (md_start),
        .md_op       (md_op),
        .md_kill     (md_kill)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        logic [11:0] got;
        rst = 1'b1; valid_d = 1'b1; op = 7'h33; funct3 = 3'd0; funct7 = 7'h20;
        stall_in = 1'b0; flush = 1'b0;
        tick();
        got = {ALUControlE, valid_e, illegal_e, stall_d, md_start, md_op, md_kill};
        total++;
        if (got !== 12'h000) begin
            bad++;
            $display("FAIL reset_outputs got=%h want=000", got);
        end
        rst = 1'b0; valid_d = 1'b0;
    endtask

    // Vector: {op, funct3, funct7, ctrl, illegal}
    task automatic test_rtype;
        logic [21:0] v [12];
        logic [5:0]  exp;
        v = '{{7'h33, 3'd0, 7'h00, 4'd0, 1'b0}, {7'h33, 3'd0, 7'h20, 4'd1, 1'b0},
              {7'h33, 3'd1, 7'h00, 4'd7, 1'b0}, {7'h33, 3'd2, 7'h00, 4'd5, 1'b0},
              {7'h33, 3'd3, 7'h00, 4'd6, 1'b0}, {7'h33, 3'd4, 7'h00, 4'd4, 1'b0},
              {7'h33, 3'd5, 7'h00, 4'd8, 1'b0}, {7'h33, 3'd5, 7'h20, 4'd9, 1'b0},
              {7'h33, 3'd6, 7'h00, 4'd3, 1'b0}, {7'h33, 3'd7, 7'h00, 4'd2, 1'b0},
              {7'h33, 3'd1, 7'h20, 4'd0, 1'b1}, {7'h33, 3'd0, 7'h10, 4'd0, 1'b1}};
        for (int i = 0; i < 12; i++) begin
            valid_d = 1'b1; op = v[i][21:15]; funct3 = v[i][14:12]; funct7 = v[i][11:5];
            exp = {1'b1, v[i][0], v[i][4:1]};
            tick();
            total++;
            if ({valid_e, illegal_e, ALUControlE} !== exp) begin
                bad++;
                $display("FAIL rtype[%0d] got=%h want=%h", i,
                         {valid_e, illegal_e, ALUControlE}, exp);
            end
        end
    endtask

    task automatic test_itype;
        logic [21:0] v [11];
        logic [5:0]  exp;
        v = '{{7'h13, 3'd0, 7'h15, 4'd0, 1'b0}, {7'h13, 3'd5, 7'h20, 4'd9, 1'b0},
              {7'h13, 3'd1, 7'h20, 4'd0, 1'b1}, {7'h13, 3'd1, 7'h00, 4'd7, 1'b0},
              {7'h13, 3'd5, 7'h00, 4'd8, 1'b0}, {7'h13, 3'd5, 7'h10, 4'd0, 1'b1},
              {7'h13, 3'd2, 7'h7f, 4'd5, 1'b0}, {7'h13, 3'd3, 7'h00, 4'd6, 1'b0},
              {7'h13, 3'd4, 7'h00, 4'd4, 1'b0}, {7'h13, 3'd6, 7'h00, 4'd3, 1'b0},
              {7'h13, 3'd7, 7'h00, 4'd2, 1'b0}};
        for (int i = 0; i < 11; i++) begin
            valid_d = 1'b1; op = v[i][21:15]; funct3 = v[i][14:12]; funct7 = v[i][11:5];
            exp = {1'b1, v[i][0], v[i][4:1]};
            tick();
            total++;
            if ({valid_e, illegal_e, ALUControlE} !== exp) begin
                bad++;
                $display("FAIL itype[%0d] got=%h want=%h", i,
                         {valid_e, illegal_e, ALUControlE}, exp);
            end
        end
    endtask

    task automatic test_other_ops;
        logic [21:0] v [10];
        logic [5:0]  exp;
        v = '{{7'h03, 3'd2, 7'h00, 4'd0, 1'b0}, {7'h23, 3'd2, 7'h00, 4'd0, 1'b0},
              {7'h67, 3'd0, 7'h00, 4'd0, 1'b0}, {7'h6f, 3'd5, 7'h3c, 4'd0, 1'b0},
              {7'h63, 3'd0, 7'h00, 4'd1, 1'b0}, {7'h63, 3'd7, 7'h00, 4'd1, 1'b0},
              {7'h63, 3'd2, 7'h00, 4'd0, 1'b1}, {7'h37, 3'd0, 7'h00, 4'd10, 1'b0},
              {7'h7f, 3'd0, 7'h00, 4'd0, 1'b1}, {7'h17, 3'd0, 7'h00, 4'd0, 1'b1}};
        for (int i = 0; i < 10; i++) begin
            valid_d = 1'b1; op = v[i][21:15]; funct3 = v[i][14:12]; funct7 = v[i][11:5];
            exp = {1'b1, v[i][0], v[i][4:1]};
            tick();
            total++;
            if ({valid_e, illegal_e, ALUControlE} !== exp) begin
                bad++;
                $display("FAIL other[%0d] got=%h want=%h", i,
                         {valid_e, illegal_e, ALUControlE}, exp);
            end
        end
    endtask

    task automatic test_hold_flush;
        // Capture sub, then stall with LUI on decode: output must hold.
        valid_d = 1'b1; op = 7'h33; funct3 = 3'd0; funct7 = 7'h20;
        tick();
        stall_in = 1'b1; op = 7'h37;
        tick();
        total++;
        if ({valid_e, illegal_e, ALUControlE} !== 6'h21) begin
            bad++;
            $display("FAIL stall_hold got=%h want=21", {valid_e, illegal_e, ALUControlE});
        end
        // Illegal op on decode, flush wins over stall.
        op = 7'h7f; flush = 1'b1;
        tick();
        total++;
        if ({valid_e, illegal_e, ALUControlE} !== 6'h00) begin
            bad++;
            $display("FAIL flush_clear got=%h want=00", {valid_e, illegal_e, ALUControlE});
        end
        flush = 1'b0; stall_in = 1'b0; valid_d = 1'b0; op = 7'h37;
        tick();
        total++;
        if ({valid_e, illegal_e, ALUControlE} !== 6'h0a) begin
            bad++;
            $display("FAIL invalid_capture got=%h want=0a", {valid_e, illegal_e, ALUControlE});
        end
        op = 7'h7f;
        tick();
        total++;
        if ({valid_e, illegal_e, ALUControlE} !== 6'h00) begin
            bad++;
            $display("FAIL invalid_illegal got=%h want=00", {valid_e, illegal_e, ALUControlE});
        end
    endtask

`ifdef ALU_CTRL_MEXT_EN
    task automatic test_muldiv;
        logic [5:0] exp;
        valid_d = 1'b1; op = 7'h33; funct7 = 7'h01; funct3 = 3'd4;
        tick();
        valid_d = 1'b0;
        for (int i = 0; i < MdCycles; i++) begin
            exp = {1'b1, (i == 0), 1'b0, 3'd4};
            total++;
            if ({stall_d, md_start, valid_e, md_op} !== exp) begin
                bad++;
                $display("FAIL md_busy[%0d] got=%h want=%h", i,
                         {stall_d, md_start, valid_e, md_op}, exp);
            end
            tick();
        end
        total++;
        if ({stall_d, valid_e, illegal_e, ALUControlE} !== 7'h2c) begin
            bad++;
            $display("FAIL md_result got=%h want=2c",
                     {stall_d, valid_e, illegal_e, ALUControlE});
        end
        tick();
        total++;
        if (valid_e !== 1'b0) begin
            bad++;
            $display("FAIL md_after got=%b want=0", valid_e);
        end
    endtask

    task automatic test_md_flush;
        valid_d = 1'b1; op = 7'h33; funct7 = 7'h01; funct3 = 3'd0;
        tick();
        valid_d = 1'b0;
        tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        total++;
        if ({stall_d, md_kill, valid_e} !== 3'b010) begin
            bad++;
            $display("FAIL md_flush got=%b want=010", {stall_d, md_kill, valid_e});
        end
        for (int i = 0; i < 5; i++) begin
            tick();
            total++;
            if ({stall_d, md_kill, valid_e} !== 3'b000) begin
                bad++;
                $display("FAIL md_flush_after[%0d] got=%b want=000", i,
                         {stall_d, md_kill, valid_e});
            end
        end
    endtask

    task automatic test_md_stall;
        valid_d = 1'b1; op = 7'h33; funct7 = 7'h01; funct3 = 3'd1;
        tick();
        valid_d = 1'b0;
        for (int i = 0; i < MdCycles - 1; i++) tick();
        stall_in = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            total++;
            if ({stall_d, valid_e} !== 2'b10) begin
                bad++;
                $display("FAIL md_stall[%0d] got=%b want=10", i, {stall_d, valid_e});
            end
        end
        stall_in = 1'b0;
        tick();
        total++;
        if ({stall_d, valid_e, ALUControlE} !== 6'h1c) begin
            bad++;
            $display("FAIL md_stall_result got=%h want=1c", {stall_d, valid_e, ALUControlE});
        end
    endtask

    task automatic test_md_accept_stall;
        stall_in = 1'b1; valid_d = 1'b1; op = 7'h33; funct7 = 7'h01; funct3 = 3'd2;
        tick();
        total++;
        if ({stall_d, md_start} !== 2'b00) begin
            bad++;
            $display("FAIL md_no_accept got=%b want=00", {stall_d, md_start});
        end
        stall_in = 1'b0;
        tick();
        valid_d = 1'b0;
        total++;
        if ({stall_d, md_start, md_op} !== 5'b11010) begin
            bad++;
            $display("FAIL md_late_accept got=%b want=11010", {stall_d, md_start, md_op});
        end
        flush = 1'b1;
        tick();
        flush = 1'b0;
        tick();
    endtask

    task automatic test_rst_busy;
        logic [11:0] got;
        valid_d = 1'b1; op = 7'h33; funct7 = 7'h01; funct3 = 3'd3;
        tick();
        valid_d = 1'b0;
        tick();
        #2 rst = 1'b1;
        #1;
        got = {ALUControlE, valid_e, illegal_e, stall_d, md_start, md_op, md_kill};
        total++;
        if (got !== 12'h000) begin
            bad++;
            $display("FAIL rst_busy got=%h want=000", got);
        end
        #1 rst = 1'b0;
        valid_d = 1'b1; op = 7'h33; funct7 = 7'h00; funct3 = 3'd6;
        tick();
        total++;
        if ({md_kill, stall_d, valid_e, illegal_e, ALUControlE} !== 8'h23) begin
            bad++;
            $display("FAIL rst_recover got=%h want=23",
                     {md_kill, stall_d, valid_e, illegal_e, ALUControlE});
        end
        valid_d = 1'b0;
    endtask
`else
    task automatic test_no_mext;
        valid_d = 1'b1; op = 7'h33; funct7 = 7'h01; funct3 = 3'd0;
        for (int i = 0; i < 3; i++) begin
            tick();
            total++;
            if ({valid_e, illegal_e, ALUControlE, stall_d, md_start, md_op, md_kill} !==
                12'b1100_0000_0000) begin
                bad++;
                $display("FAIL no_mext[%0d] got=%b want=110000000000", i,
                         {valid_e, illegal_e, ALUControlE, stall_d, md_start, md_op, md_kill});
            end
        end
        valid_d = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_rtype();
        test_itype();
        test_other_ops();
        test_hold_flush();
`ifdef ALU_CTRL_MEXT_EN
        test_muldiv();
        test_md_flush();
        test_md_stall();
        test_md_accept_stall();
        test_rst_busy();
`else
        test_no_mext();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu_ctrl_pipe.md
ALU_CTRL_PIPE -- requirements
Module: alu_ctrl_pipe

Interface
REQ-001 SHALL have parameter CTRL_W, default 4, ALU control width (min 4; upper bits zero-extended).
REQ-002 SHALL have parameter MD_CYCLES, default 4, busy cycles per multiply/divide op (min 2).
REQ-003 SHALL have clk  input  1  rising-edge clock.
REQ-004 SHALL have rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have valid_d  input  1  decode-stage instruction valid.
REQ-006 SHALL have op  input  7 | funct3  input  3 | funct7  input  7  instruction fields.
REQ-007 SHALL have stall_in  input  1  downstream hold | flush  input  1  kill in-flight op.
REQ-008 SHALL have ALUControlE  output  CTRL_W  registered ALU select | valid_e  output  1 | illegal_e  output  1.
REQ-009 SHALL have stall_d  output  1  hold decode stage | md_start  output  1 | md_op  output  3 | md_kill  output  1.

Function
REQ-010 Codes SHALL be: add 0, sub 1, and 2, or 3, xor 4, slt 5, sltu 6, sll 7, srl 8, sra 9, passB 10, muldiv 12.
REQ-011 R-type 0110011, funct7 0x00/0x20: funct3 0 add/sub, 1 sll, 2 slt, 3 sltu, 4 xor, 5 srl/sra, 6 or, 7 and; funct7 0x20 legal only with funct3 0/5.
REQ-012 I-type 0010011: funct3 as R-type without sub; funct3 5 uses funct7 0x00 srl / 0x20 sra; funct3 1 requires funct7 0x00.
REQ-013 Load 0000011, store 0100011, JALR 1100111, JAL 1101111 SHALL yield add; branch 1100011 funct3 0/1/4/5/6/7 SHALL yield sub; LUI 0110111 SHALL yield passB.
REQ-014 Any other op/funct combination SHALL yield add with illegal_e=1 when captured.
REQ-015 Output register: flush -> valid_e=0, ALUControlE=0, illegal_e=0; else stall_in or FSM BUSY -> hold; else capture decode, valid_e=valid_d; latency 1 cycle.
REQ-016 FSM states IDLE, BUSY; stall_d = (state==BUSY).
REQ-017 IDLE, valid_d, R-type funct7 0x01, no stall_in, no flush: accept; state->BUSY, counter<=MD_CYCLES-1, md_op<=funct3, output loads valid_e=0.
REQ-018 md_start SHALL be a one-cycle registered pulse in the first BUSY cycle; md_op held stable throughout BUSY.
REQ-019 BUSY: counter decrements each cycle until 0; at counter 0 with stall_in low: state->IDLE, output loads ALUControlE=12, valid_e=1; with stall_in high stay BUSY at 0.
REQ-020 Result valid_e SHALL rise exactly MD_CYCLES edges after acceptance edge when stall_in stays low.
REQ-021 flush during BUSY: state->IDLE, counter->0, md_kill one-cycle pulse next cycle, no valid_e for the killed op; flush has priority over all simultaneous events.
REQ-022 M-op arriving while stall_in high SHALL not be accepted; decode holds until stall_in low.

Reset
REQ-023 rst SHALL asynchronously force state IDLE, counter 0, ALUControlE 0, valid_e 0, illegal_e 0, md_start 0, md_op 0, md_kill 0, stall_d 0.
REQ-024 Reset mid-BUSY SHALL abandon the op with no md_kill pulse; first legal capture on first edge after rst deasserts.

Configuration
REQ-025 Macro ALU_CTRL_MEXT_EN defined: REQ-017..REQ-022 active.
REQ-026 Macro undefined: funct7 0x01 R-type decodes as illegal (add, illegal_e=1), FSM never leaves IDLE, stall_d/md_start/md_kill tied 0, md_op 0.

Verification
REQ-027 op 0110011, funct3 0, funct7 0x20, valid_d=1 -> next cycle ALUControlE=1, valid_e=1, illegal_e=0.
REQ-028 op 0010011, funct3 5, funct7 0x20 -> ALUControlE=9; funct3 1, funct7 0x20 -> ALUControlE=0, illegal_e=1.
REQ-029 MEXT_EN, MD_CYCLES=4, mul (funct7 0x01, funct3 0) -> md_start pulse cycle+1, stall_d high 4 cycles, valid_e=1 with ALUControlE=12 at edge 4.
REQ-030 Same op, flush in 2nd BUSY cycle -> stall_d low next cycle, md_kill pulse once, valid_e never 1 for it.
REQ-031 stall_in high on counter-0 cycle for 3 cycles -> stays BUSY, ALUControlE held, result captured first edge stall_in low.
REQ-032 rst asserted mid-BUSY -> all outputs 0 immediately, no md_kill; macro off: mul -> illegal_e=1, stall_d=0.
